mips_irq_ctl: RTL and testbench

MIPS_IRQ_CTL -- requirements
Module: mips_irq_ctl

---
 rtl/mips_irq_ctl.sv | 144 ++++++++++++++
 tb/tb_mips_irq_ctl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_irq_ctl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mips_irq_ctl
// Brief    : Edge-triggered interrupt controller with a memory-mapped register
//            window, lowest-index priority and IDLE/REQ/SERVE handshake.
// Revision : 1.0
// ============================================================================
module mips_irq_ctl #(
    parameter int          N_SRC     = 8,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter logic [3:0]  MEM_RD_W  = 4'd1,
    parameter logic [3:0]  MEM_WR_W  = 4'd2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src_i,
    input  logic [31:0]      cop_addr_i,
    input  logic [31:0]      cop_data_i,
    input  logic [3:0]       cop_mem_ctl_i,
    output logic [31:0]      cop_dout_o,
    output logic             irq_o,
    output logic [31:0]      irq_addr_o,
    input  logic             iack_i
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_SERVE = 2'd2
    } state_t;

    state_t             r_state;
    logic [N_SRC-1:0]   r_sync1, r_sync2, r_sync3;
    logic [N_SRC-1:0]   r_pending, r_mask;
    logic [31:0]        r_vecbase;
    logic [IDX_W-1:0]   r_cause, r_idx;
    logic               r_irq;
    logic [31:0]        r_irq_addr, r_dout;

    logic               w_hit, w_rd, w_wr;
    logic [7:0]         w_off;
    logic [N_SRC-1:0]   w_rise, w_w1c, w_ack_clr, w_active;
    logic [IDX_W-1:0]   w_sel;
    logic [31:0]        w_vec, w_rdata;

    assign w_hit    = (cop_addr_i[31:8] == BASE_ADDR[31:8]);
    assign w_off    = cop_addr_i[7:0];
    assign w_rd     = w_hit && (cop_mem_ctl_i == MEM_RD_W);
    assign w_wr     = w_hit && (cop_mem_ctl_i == MEM_WR_W);
    assign w_rise   = r_sync2 & ~r_sync3;
    assign w_w1c    = (w_wr && w_off == 8'h00) ? cop_data_i[N_SRC-1:0] : '0;
    assign w_active = r_pending & r_mask;

    always_comb begin
        w_ack_clr = '0;
        if (r_state == S_REQ && iack_i)
            w_ack_clr[r_idx] = 1'b1;
    end

    // Scan downwards so the lowest active index is the one left standing.
    always_comb begin
        w_sel = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (w_active[i])
                w_sel = IDX_W'(i);
    end

    assign w_vec = r_vecbase + (32'(w_sel) << 4);

    always_comb begin
        w_rdata = '0;
        case (w_off)
            8'h00:   w_rdata[N_SRC-1:0] = r_pending;
            8'h04:   w_rdata[N_SRC-1:0] = r_mask;
            8'h08:   w_rdata            = r_vecbase;
            8'h0C:   w_rdata[IDX_W-1:0] = r_cause;
            default: w_rdata            = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sync3    <= '0;
            r_pending  <= '0;
            r_mask     <= '0;
            r_vecbase  <= '0;
            r_cause    <= '0;
            r_idx      <= '0;
            r_irq      <= 1'b0;
            r_irq_addr <= '0;
            r_dout     <= '0;
            r_state    <= S_IDLE;
        end else begin
            r_sync1   <= irq_src_i;
            r_sync2   <= r_sync1;
            r_sync3   <= r_sync2;
            // A fresh edge outranks any clear landing in the same cycle.
            r_pending <= (r_pending & ~w_w1c & ~w_ack_clr) | w_rise;
            r_dout    <= w_rd ? w_rdata : 32'h0;

            if (w_wr && w_off == 8'h04)
                r_mask <= cop_data_i[N_SRC-1:0];
            if (w_wr && w_off == 8'h08)
                r_vecbase <= {cop_data_i[31:4], 4'h0};

            case (r_state)
                S_IDLE: begin
                    if (|w_active) begin
                        r_state    <= S_REQ;
                        r_irq      <= 1'b1;
                        r_idx      <= w_sel;
                        r_irq_addr <= w_vec;
                    end
                end
                S_REQ: begin
                    if (iack_i) begin
                        r_state <= S_SERVE;
                        r_irq   <= 1'b0;
                        r_cause <= r_idx;
                    end
                end
                S_SERVE: begin
                    if (w_wr && w_off == 8'h10)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_irq   <= 1'b0;
                end
            endcase
        end
    end

    assign cop_dout_o = r_dout;
    assign irq_o      = r_irq;
    assign irq_addr_o = r_irq_addr;

endmodule
`default_nettype wire

// File: tb/tb_mips_irq_ctl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mips_irq_ctl
// Brief    : Directed self-checking bench for mips_irq_ctl.
// Revision : 1.0
// ============================================================================
module tb_mips_irq_ctl;

    localparam logic [3:0]  RD = 4'd1;
    localparam logic [3:0]  WR = 4'd2;
    localparam logic [31:0] WIN = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_src;
    logic [31:0] addr, wdata, dout, irq_addr, rd;
    logic [3:0]  ctl;
    logic        irq, iack;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_irq_ctl #(
        .N_SRC(8), .BASE_ADDR(WIN), .MEM_RD_W(RD), .MEM_WR_W(WR)
    ) dut (
        .clk(clk), .rst(rst), .irq_src_i(irq_src), .cop_addr_i(addr),
        .cop_data_i(wdata), .cop_mem_ctl_i(ctl), .cop_dout_o(dout),
        .irq_o(irq), .irq_addr_o(irq_addr), .iack_i(iack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [7:0] off, input logic [31:0] d);
        addr = WIN | 32'(off); wdata = d; ctl = WR;
        tick();
        ctl = 4'd0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; ctl = RD;
        tick();
        ctl = 4'd0;
        d = dout;
    endtask

    task automatic pulse(input logic [7:0] m);
        irq_src = irq_src | m;
        repeat (3) tick();
        irq_src = irq_src & ~m;
    endtask

    task automatic ack();
        iack = 1'b1;
        tick();
        iack = 1'b0;
    endtask

    task automatic wait_irq(input string name);
        for (int k = 0; k < 10 && irq !== 1'b1; k++) tick();
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL %s irq timeout: irq=%b required 1", name, irq);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; irq_src = '0; addr = '0; wdata = '0; ctl = '0; iack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b req 0", irq); end
        n_cmp++; if (irq_addr !== 32'h0) begin n_err++; $display("FAIL reset_irq_addr got %h req 0", irq_addr); end
        n_cmp++; if (dout !== 32'h0) begin n_err++; $display("FAIL reset_dout got %h req 0", dout); end
        rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus_rd(WIN | 32'(i * 4), rd);
            n_cmp++;
            if (rd !== 32'h0) begin n_err++; $display("FAIL reset_reg%0d got %h req 0", i, rd); end
        end
    endtask

    task automatic test_regmap();
        bus_wr(8'h04, 32'hFFFF_FFFF);
        bus_rd(WIN | 32'h04, rd);
        n_cmp++; if (rd !== 32'h0000_00FF) begin n_err++; $display("FAIL mask_upper got %h req 000000ff", rd); end
        tick();
        n_cmp++; if (dout !== 32'h0) begin n_err++; $display("FAIL dout_idle got %h req 0", dout); end
        bus_wr(8'h04, 32'h0000_00A5);
        bus_wr(8'h14, 32'h1234_5678);
        bus_rd(WIN | 32'h04, rd);
        n_cmp++; if (rd !== 32'h0000_00A5) begin n_err++; $display("FAIL mask_rw got %h req 000000a5", rd); end
        bus_rd(WIN | 32'h14, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL unmapped_rd got %h req 0", rd); end
        bus_rd(32'hFFFF_FE04, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL miss_rd got %h req 0", rd); end
        bus_wr(8'h04, 32'h0);
        bus_wr(8'h08, 32'h0000_100F);
        bus_rd(WIN | 32'h08, rd);
        n_cmp++; if (rd !== 32'h0000_1000) begin n_err++; $display("FAIL vecbase_low got %h req 00001000", rd); end
    endtask

    task automatic test_basic();
        bus_wr(8'h04, 32'h04);
        pulse(8'h04);
        wait_irq("basic");
        n_cmp++; if (irq_addr !== 32'h0000_1020) begin n_err++; $display("FAIL basic_vec got %h req 00001020", irq_addr); end
        ack();
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL basic_ack_irq got %b req 0", irq); end
        bus_rd(WIN | 32'h0C, rd);
        n_cmp++; if (rd !== 32'd2) begin n_err++; $display("FAIL basic_cause got %h req 2", rd); end
        bus_rd(WIN | 32'h00, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL basic_pending got %h req 0", rd); end
        bus_wr(8'h10, 32'h0);
        repeat (3) tick();
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL basic_after_eoi got %b req 0", irq); end
    endtask

    task automatic test_priority();
        bus_wr(8'h04, 32'hFF);
        pulse(8'h22);
        wait_irq("prio1");
        n_cmp++; if (irq_addr !== 32'h0000_1010) begin n_err++; $display("FAIL prio_first got %h req 00001010", irq_addr); end
        ack();
        bus_wr(8'h10, 32'h0);
        wait_irq("prio2");
        n_cmp++; if (irq_addr !== 32'h0000_1050) begin n_err++; $display("FAIL prio_second got %h req 00001050", irq_addr); end
        ack();
        bus_rd(WIN | 32'h0C, rd);
        n_cmp++; if (rd !== 32'd5) begin n_err++; $display("FAIL prio_cause got %h req 5", rd); end
        bus_wr(8'h10, 32'h0);
    endtask

    task automatic test_masked();
        bus_wr(8'h04, 32'h0);
        pulse(8'h01);
        repeat (3) tick();
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL masked_irq got %b req 0", irq); end
        bus_rd(WIN | 32'h00, rd);
        n_cmp++; if (rd !== 32'h01) begin n_err++; $display("FAIL masked_pending got %h req 1", rd); end
        bus_wr(8'h04, 32'h01);
        wait_irq("unmask");
        n_cmp++; if (irq_addr !== 32'h0000_1000) begin n_err++; $display("FAIL unmask_vec got %h req 00001000", irq_addr); end
        ack();
        bus_wr(8'h10, 32'h0);
    endtask

    task automatic test_serve();
        bus_wr(8'h04, 32'hFF);
        pulse(8'h40);
        wait_irq("serve_first");
        n_cmp++; if (irq_addr !== 32'h0000_1060) begin n_err++; $display("FAIL serve_first_vec got %h req 00001060", irq_addr); end
        ack();
        pulse(8'h08);
        repeat (3) tick();
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL serve_blocked got %b req 0", irq); end
        ack();
        bus_rd(WIN | 32'h00, rd);
        n_cmp++; if (rd !== 32'h08) begin n_err++; $display("FAIL serve_pending got %h req 8", rd); end
        bus_rd(WIN | 32'h0C, rd);
        n_cmp++; if (rd !== 32'd6) begin n_err++; $display("FAIL serve_cause got %h req 6", rd); end
        bus_wr(8'h10, 32'h0);
        wait_irq("serve_eoi");
        n_cmp++; if (irq_addr !== 32'h0000_1030) begin n_err++; $display("FAIL serve_vec3 got %h req 00001030", irq_addr); end
        ack();
        bus_wr(8'h10, 32'h0);
    endtask

    task automatic test_w1c_race();
        bus_wr(8'h04, 32'h0);
        pulse(8'h08);
        repeat (4) tick();
        bus_wr(8'h00, 32'h08);
        bus_rd(WIN | 32'h00, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL w1c_plain got %h req 0", rd); end
        pulse(8'h08);
        repeat (4) tick();
        irq_src[3] = 1'b1;
        tick();
        tick();
        bus_wr(8'h00, 32'h08);
        irq_src[3] = 1'b0;
        bus_rd(WIN | 32'h00, rd);
        n_cmp++; if (rd !== 32'h08) begin n_err++; $display("FAIL w1c_race got %h req 8", rd); end
        repeat (4) tick();
        bus_wr(8'h00, 32'h08);
    endtask

    task automatic test_reset_mid();
        bus_wr(8'h04, 32'hFF);
        pulse(8'h10);
        wait_irq("rst_mid");
        rst = 1'b0;
        #1;
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rstmid_irq got %b req 0", irq); end
        n_cmp++; if (irq_addr !== 32'h0) begin n_err++; $display("FAIL rstmid_addr got %h req 0", irq_addr); end
        tick();
        rst = 1'b1;
        repeat (6) tick();
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rstmid_spurious got %b req 0", irq); end
        bus_rd(WIN | 32'h04, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rstmid_mask got %h req 0", rd); end
        bus_rd(WIN | 32'h00, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rstmid_pending got %h req 0", rd); end
        bus_rd(32'h0000_0008, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rstmid_nonwin got %h req 0", rd); end
    endtask

    initial begin
        test_reset();
        test_regmap();
        test_basic();
        test_priority();
        test_masked();
        test_serve();
        test_w1c_race();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
